window_frame_sequencer: RTL and testbench
=========================================

Name: window_frame_sequencer

Overview:
- Collects the audio sample stream into overlapping analysis frames and replays each frame as a fast burst toward the Hanning window / FFT path.
- Drives the window coefficient ROM address in lockstep with the replayed samples.
- Marks frame start and frame end for the downstream block.
- Sits between the audio sample source and the windowing multiplier.

Parameters:
- DATA_WIDTH, 8, signed sample width.
- SAMPLE_COUNT, 4096, frame length N; must be a power of two.
- HOP, 1024, new samples per frame; must satisfy 1 <= HOP <= SAMPLE_COUNT.
- READ_LATENCY, 2, sample buffer read latency in cycles; matches the coefficient ROM latency.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset.
- sample_in  input  DATA_WIDTH  signed audio sample.
- sample_valid_in  input  1  one-cycle strobe; sample_in is valid this cycle.
- ready_in  input  1  downstream can accept a new frame burst.
- coeff_addr_out  output  $clog2(SAMPLE_COUNT)  window coefficient index k, issued in the same cycle as buffer read k.
- sample_out  output  DATA_WIDTH  replayed sample k.
- sample_valid_out  output  1  sample_out valid.
- frame_start_out  output  1  coincides with k=0 on sample_valid_out.
- frame_last_out  output  1  coincides with k=N-1 on sample_valid_out.
- busy_out  output  1  burst in progress.
- drop_count_out  output  16  frames skipped due to overrun.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n_in low at a clock edge) clears all of the following to 0: outputs, write pointer, fill counter, hop counter, pending flag and state. Buffer contents are don't-care.
- Reset mid-burst aborts the burst immediately; no further sample_valid_out pulses.
- Write side (always active, including during a burst):
  - On sample_valid_in, write sample_in at wr_ptr, then wr_ptr++ modulo N.
  - Fill counter saturates at N.
  - Hop counter counts modulo HOP.
- Frame due when either:
  - the fill counter reaches N for the first time, or
  - thereafter, the hop counter wraps.
- Pending flag:
  - A due frame sets pending.
  - If pending is already set, or a burst is active while another frame becomes due, drop_count_out increments, saturating at 16'hFFFF. Only one frame stays pending.
- States:
  - FILL: waiting until the fill counter reaches N. Go to IDLE when fill reaches N.
  - IDLE: if pending && ready_in, latch base = wr_ptr (the oldest sample), clear pending, go to BURST. ready_in is sampled only here.
  - BURST: each cycle, issue a read at (base+k) mod N and drive coeff_addr_out=k, for k=0..N-1 across N consecutive cycles. After issuing k=N-1, go to DRAIN.
  - DRAIN: wait READ_LATENCY cycles, then go to IDLE.
- Output timing:
  - sample_out / sample_valid_out for index k appear exactly READ_LATENCY cycles after coeff_addr_out=k.
  - busy_out is high in BURST and DRAIN.
- Simultaneous write and read of the same address during a burst: the read returns the old data (read-first). This guarantees frame integrity as long as fewer than HOP samples arrive during a burst.
- A frame that becomes due and enters IDLE in the same cycle is started on the next cycle.

Optional Feature:
- Macro: WINDOW_SEQ_DROP_COUNT_EN.
- When defined: drop counter as specified.
- When undefined: no counter logic; drop_count_out is tied to 0, and a newly due frame simply re-sets an already-set pending flag.

Decomposition:
- Package window_pkg holds:
  - state enum typedef (FILL, IDLE, BURST, DRAIN);
  - default SAMPLE_COUNT, HOP and READ_LATENCY constants;
  - derived ADDR_WIDTH.
- One sub-module, frame_sample_ram: simple dual-port read-first buffer of N x DATA_WIDTH with READ_LATENCY-cycle registered read.
- The sequencer FSM and pointer logic stay in the top module.

Test Plan (bench uses N=8, HOP=4, READ_LATENCY=2, ready_in=1 unless noted):
- Fill: strobe samples 1..8 -> no valid output before sample 8. Then 8 valid outputs in consecutive cycles carrying 1..8 and coeff index 0..7; frame_start on value 1, frame_last on value 8.
- Hop: strobe samples 9..12 -> second burst carrying 5..12; frame_start on 5.
- Backpressure: ready_in=0 when the frame becomes due -> no burst. Raise ready_in 20 cycles later -> burst begins the cycle after; drop_count_out stays 0.
- Overrun: hold ready_in=0 while 8 more samples arrive (two hops) -> drop_count_out=1. Releasing ready_in yields one burst containing the 8 newest samples.
- Write during burst: strobe sample 13 in the burst's third cycle -> current frame remains 5..12; the next frame includes 13.
- Reset mid-burst: assert rst_n_in low at k=3 -> sample_valid_out goes 0 from the next cycle; busy_out=0; no output until 8 fresh samples arrive.

Source files
------------

// File: rtl/window_pkg.sv
// Shared state encoding and default geometry for the window frame sequencer.
// The optional overrun counter is enabled by defining WINDOW_SEQ_DROP_COUNT_EN.
package window_pkg;

    localparam int DEFAULT_SAMPLE_COUNT = 4096;
    localparam int DEFAULT_HOP          = 1024;
    localparam int DEFAULT_READ_LATENCY = 2;
    localparam int ADDR_WIDTH           = $clog2(DEFAULT_SAMPLE_COUNT);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/frame_sample_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// READ_LATENCY-deep registered read path. Reads see the old data on a collision.
module frame_sample_ram
    import window_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = DEFAULT_SAMPLE_COUNT,
    parameter int ADDR_W       = ADDR_WIDTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_W-1:0]     wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic [ADDR_W-1:0]     rd_addr_in,
    output logic [DATA_WIDTH-1:0] rd_data_out
);

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

    // Storage is not reset; only the read pipeline is, so outputs come up at 0.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    always_comb begin
        pipe_d[0] = mem_q[rd_addr_in];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign rd_data_out = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/window_frame_sequencer.sv
// Buffers the sample stream into overlapping N-sample frames and replays each
// frame as an N-cycle burst. Overrun counter enabled by WINDOW_SEQ_DROP_COUNT_EN.
module window_frame_sequencer
    import window_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SAMPLE_COUNT = DEFAULT_SAMPLE_COUNT,
    parameter int HOP          = DEFAULT_HOP,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic signed [DATA_WIDTH-1:0]    sample_in,
    input  logic                            sample_valid_in,
    input  logic                            ready_in,
    output logic [$clog2(SAMPLE_COUNT)-1:0] coeff_addr_out,
    output logic signed [DATA_WIDTH-1:0]    sample_out,
    output logic                            sample_valid_out,
    output logic                            frame_start_out,
    output logic                            frame_last_out,
    output logic                            busy_out,
    output logic [15:0]                     drop_count_out
);

    localparam int AW = $clog2(SAMPLE_COUNT);
    localparam int FW = AW + 1;
    localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [FW-1:0] FILL_FULL  = FW'(SAMPLE_COUNT);
    localparam logic [HW-1:0] HOP_LAST   = HW'(HOP - 1);
    localparam logic [AW-1:0] K_LAST     = AW'(SAMPLE_COUNT - 1);
    localparam logic [LW-1:0] DRAIN_LAST = LW'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic [HW-1:0]           hop_q, hop_d;
    logic                    pending_q, pending_d;
    logic [AW-1:0]           base_q, base_d;
    logic [AW-1:0]           k_q, k_d;
    logic [LW-1:0]           drain_q, drain_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] first_q, first_d;
    logic [READ_LATENCY-1:0] last_q, last_d;

    logic                    frame_due;
    logic                    start_burst;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   rd_data;

    // Write side runs every cycle, independent of the replay state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        hop_d     = hop_q;
        frame_due = 1'b0;
        if (sample_valid_in) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_d    = fill_q + 1'b1;
                frame_due = (fill_q == FILL_FULL - 1'b1);
            end else begin
                hop_d     = (hop_q == HOP_LAST) ? '0 : hop_q + 1'b1;
                frame_due = (hop_q == HOP_LAST);
            end
        end
    end

    // Handshake: ready_in is a level sampled only in IDLE with a frame pending;
    // sample_valid_out marks each replayed sample, with no stall once a burst starts.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        drain_d     = drain_q;
        start_burst = 1'b0;
        case (state_q)
            FILL: begin
                if (fill_d == FILL_FULL) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pending_q && ready_in) begin
                    start_burst = 1'b1;
                    base_d      = wr_ptr_d;
                    k_d         = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign busy = (state_q == BURST) || (state_q == DRAIN);

    always_comb begin
        pending_d = pending_q && !start_burst;
        if (frame_due) begin
            pending_d = 1'b1;
        end
    end

    // Frame markers travel alongside the read so they line up with sample_out.
    always_comb begin
        vld_d[0]   = (state_q == BURST);
        first_d[0] = (state_q == BURST) && (k_q == '0);
        last_d[0]  = (state_q == BURST) && (k_q == K_LAST);
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            first_d[i] = first_q[i-1];
            last_d[i]  = last_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= FILL;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            hop_q     <= '0;
            pending_q <= 1'b0;
            base_q    <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            vld_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            hop_q     <= hop_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

`ifdef WINDOW_SEQ_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    // A due frame is an overrun if the pending slot stays occupied or a burst is running.
    always_comb begin
        drop_d = drop_q;
        if (frame_due && ((pending_q && !start_burst) || busy) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count_out = drop_q;
`else
    assign drop_count_out = 16'd0;
`endif

    frame_sample_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (SAMPLE_COUNT),
        .ADDR_W       (AW),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .wr_en_in    (sample_valid_in),
        .wr_addr_in  (wr_ptr_q),
        .wr_data_in  (sample_in),
        .rd_addr_in  (base_q + k_q),
        .rd_data_out (rd_data)
    );

    assign coeff_addr_out   = k_q;
    assign sample_out       = rd_data;
    assign sample_valid_out = vld_q[READ_LATENCY-1];
    assign frame_start_out  = first_q[READ_LATENCY-1];
    assign frame_last_out   = last_q[READ_LATENCY-1];
    assign busy_out         = busy;

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Directed bench for window_frame_sequencer with N=8, HOP=4, READ_LATENCY=2.
// Drop-count expectation follows WINDOW_SEQ_DROP_COUNT_EN.
module tb_window_frame_sequencer;

    localparam int DW  = 8;
    localparam int N   = 8;
    localparam int HOP = 4;
    localparam int LAT = 2;
`ifdef WINDOW_SEQ_DROP_COUNT_EN
    localparam logic [15:0] EXP_DROP_OVERRUN = 16'd1;
`else
    localparam logic [15:0] EXP_DROP_OVERRUN = 16'd0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic signed [DW-1:0]  sample_in;
    logic                  sample_valid_in;
    logic                  ready_in;
    logic [2:0]            coeff_addr_out;
    logic signed [DW-1:0]  sample_out;
    logic                  sample_valid_out;
    logic                  frame_start_out;
    logic                  frame_last_out;
    logic                  busy_out;
    logic [15:0]           drop_count_out;

    int checks   = 0;
    int failures = 0;

    window_frame_sequencer #(
        .DATA_WIDTH   (DW),
        .SAMPLE_COUNT (N),
        .HOP          (HOP),
        .READ_LATENCY (LAT)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .ready_in         (ready_in),
        .coeff_addr_out   (coeff_addr_out),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .frame_start_out  (frame_start_out),
        .frame_last_out   (frame_last_out),
        .busy_out         (busy_out),
        .drop_count_out   (drop_count_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        sample_in       = v[DW-1:0];
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    // Waits for a burst, then checks coefficient index, replayed values and
    // frame markers over N + LAT cycles; optionally strobes one sample at burst cycle 2.
    task automatic check_frame(input string tag, input int first, input bit inject, input int inj_val);
        int          guard;
        logic [7:0]  obs8;
        logic [7:0]  exp8;
        guard = 0;
        while (!busy_out && guard < 40) begin
            tick();
            guard++;
        end
        check({tag, "_burst_seen"}, 32'(guard < 40), 32'd1);
        for (int c = 0; c < N + LAT; c++) begin
            check({tag, "_busy"}, 32'(busy_out), 32'd1);
            if (c < N) begin
                check({tag, "_coeff"}, 32'(coeff_addr_out), 32'(c));
            end
            if (c >= LAT) begin
                obs8 = sample_out;
                exp8 = 8'(first + c - LAT);
                check({tag, "_valid"}, 32'(sample_valid_out), 32'd1);
                check({tag, "_data"}, 32'(obs8), 32'(exp8));
                check({tag, "_start"}, 32'(frame_start_out), 32'(c == LAT));
                check({tag, "_last"}, 32'(frame_last_out), 32'(c == LAT + N - 1));
            end else begin
                check({tag, "_early_valid"}, 32'(sample_valid_out), 32'd0);
            end
            if (inject && c == 2) begin
                sample_in       = inj_val[DW-1:0];
                sample_valid_in = 1'b1;
            end
            tick();
            sample_valid_in = 1'b0;
        end
        check({tag, "_end_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_end_valid"}, 32'(sample_valid_out), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n           = 1'b0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        ready_in        = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_valid", 32'(sample_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_coeff", 32'(coeff_addr_out), 32'd0);
        check("rst_start", 32'(frame_start_out), 32'd0);
        check("rst_last", 32'(frame_last_out), 32'd0);
        check("rst_drop", 32'(drop_count_out), 32'd0);
        check("rst_data", 32'({24'd0, sample_out}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill: nothing replayed until the eighth sample
        for (int i = 1; i <= N; i++) begin
            send(i);
            check("fill_no_valid", 32'(sample_valid_out), 32'd0);
            check("fill_no_busy", 32'(busy_out), 32'd0);
        end
        check_frame("fill", 1, 1'b0, 0);

        // Hop, with sample 13 written in the burst's third cycle
        for (int i = 9; i <= 12; i++) begin
            send(i);
        end
        check_frame("hop", 5, 1'b1, 13);

        // Backpressure: frame due while ready_in is low
        ready_in = 1'b0;
        for (int i = 14; i <= 16; i++) begin
            send(i);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_busy", 32'(busy_out), 32'd0);
            check("bp_hold_valid", 32'(sample_valid_out), 32'd0);
        end
        ready_in = 1'b1;
        tick();
        check("bp_start_busy", 32'(busy_out), 32'd1);
        check("bp_start_coeff", 32'(coeff_addr_out), 32'd0);
        check_frame("bp", 9, 1'b0, 0);
        check("bp_drop", 32'(drop_count_out), 32'd0);

        // Overrun: two hops while blocked
        ready_in = 1'b0;
        for (int i = 17; i <= 24; i++) begin
            send(i);
        end
        check("ovr_drop", 32'(drop_count_out), 32'(EXP_DROP_OVERRUN));
        check("ovr_idle", 32'(busy_out), 32'd0);
        ready_in = 1'b1;
        check_frame("ovr", 17, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ovr_single_burst", 32'(busy_out), 32'd0);
        end
        check("ovr_drop_hold", 32'(drop_count_out), 32'(EXP_DROP_OVERRUN));

        // Reset in the middle of a burst at k=3
        for (int i = 25; i <= 28; i++) begin
            send(i);
        end
        guard = 0;
        while (!busy_out && guard < 40) begin
            tick();
            guard++;
        end
        check("mid_burst_seen", 32'(guard < 40), 32'd1);
        repeat (3) tick();
        check("mid_coeff3", 32'(coeff_addr_out), 32'd3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(sample_valid_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_coeff", 32'(coeff_addr_out), 32'd0);
        check("mid_rst_drop", 32'(drop_count_out), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_quiet", 32'(sample_valid_out), 32'd0);
        end
        for (int i = 101; i <= 107; i++) begin
            send(i);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            check("refill_no_valid", 32'(sample_valid_out), 32'd0);
            check("refill_no_busy", 32'(busy_out), 32'd0);
        end
        send(108);
        check_frame("refill", 101, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
